// File: rtl/dcc_pkg.sv
// Shared types and default sizing for the duty-cycle-correction loop.
// The delay-line wrapper imports the same constants so tap widths stay in step.
package dcc_pkg;

    localparam int DCC_DELAY_BITS = 5;
    localparam int DCC_SETTLE     = 4;
    localparam int DCC_SAMPLES    = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DECIDE,
        LOCKED,
        TRACK
    } dcc_state_e;

endpackage

// File: rtl/dcc_sar_ctrl_sync2.sv
// Two-flop bit synchronizer with synchronous active-high reset.
module sync2 (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcc_sar_ctrl.sv
// DCC loop controller: SAR search of the delay-line tap code, then optional
// one-LSB drift tracking, each decision a majority vote over detector samples.
module dcc_sar_ctrl
    import dcc_pkg::*;
#(
    parameter int delay_bits    = DCC_DELAY_BITS,
    parameter int SETTLE_CYCLES = DCC_SETTLE,
    parameter int SAMPLES       = DCC_SAMPLES
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  track_en,
    input  logic                  pd_in,
    output logic [delay_bits-1:0] gamma,
    output logic                  busy,
    output logic                  locked
);

    localparam int IDX_W = (delay_bits > 1) ? $clog2(delay_bits) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       SCNT_MAX = 4'(SAMPLES - 1);
    localparam logic [4:0]       SAMP5    = 5'(SAMPLES);

    dcc_state_e            state, state_n;
    logic                  mode, mode_n;      // 1: track round, 0: SAR round
    logic [IDX_W-1:0]      bit_idx, bit_idx_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [3:0]            scnt, scnt_n;
    logic [3:0]            ones, ones_n;
    logic [delay_bits-1:0] gamma_n;
    logic                  busy_n, locked_n;
    logic                  pd_s;

    function automatic logic vote_high(input logic [3:0] n);
        logic [4:0] dbl;
        dbl = {n, 1'b0};
        return dbl > SAMP5;
    endfunction

    // Saturating one-LSB move; a tied vote holds the code.
    function automatic logic [delay_bits-1:0] track_step(input logic [delay_bits-1:0] g,
                                                         input logic [3:0] n);
        logic [4:0] dbl;
        dbl = {n, 1'b0};
        if (dbl > SAMP5)
            track_step = (g == '0) ? g : g - 1'b1;
        else if (dbl < SAMP5)
            track_step = (&g) ? g : g + 1'b1;
        else
            track_step = g;
    endfunction

    sync2 u_pd_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (pd_in),
        .q      (pd_s)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state   <= IDLE;
            mode    <= 1'b0;
            bit_idx <= '0;
            cnt     <= '0;
            scnt    <= '0;
            ones    <= '0;
            gamma   <= '0;
            busy    <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state   <= state_n;
            mode    <= mode_n;
            bit_idx <= bit_idx_n;
            cnt     <= cnt_n;
            scnt    <= scnt_n;
            ones    <= ones_n;
            gamma   <= gamma_n;
            busy    <= busy_n;
            locked  <= locked_n;
        end
    end

    always_comb begin
        state_n   = state;
        mode_n    = mode;
        bit_idx_n = bit_idx;
        cnt_n     = cnt;
        scnt_n    = scnt;
        ones_n    = ones;
        gamma_n   = gamma;
        busy_n    = busy;
        locked_n  = locked;
        case (state)
            IDLE, LOCKED: begin
                if (start) begin
                    bit_idx_n = IDX_W'(delay_bits - 1);
                    gamma_n   = '0;
                    gamma_n[delay_bits-1] = 1'b1;
                    busy_n    = 1'b1;
                    locked_n  = 1'b0;
                    mode_n    = 1'b0;
                    cnt_n     = CNT_MAX;
                    state_n   = SETTLE;
                end else if (state == LOCKED && track_en) begin
                    mode_n  = 1'b1;
                    cnt_n   = CNT_MAX;
                    state_n = TRACK;
                end
            end
            // TRACK is the settle phase of a track round.
            SETTLE, TRACK: begin
                if (cnt == '0) begin
                    ones_n  = '0;
                    scnt_n  = SCNT_MAX;
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SAMPLE: begin
                ones_n = ones + {3'b000, pd_s};
                if (scnt == '0)
                    state_n = DECIDE;
                else
                    scnt_n = scnt - 1'b1;
            end
            DECIDE: begin
                cnt_n = CNT_MAX;
                if (mode) begin
                    gamma_n = track_step(gamma, ones);
                    state_n = track_en ? TRACK : LOCKED;
                end else begin
                    if (vote_high(ones))
                        gamma_n[bit_idx] = 1'b0;
                    if (bit_idx == '0) begin
                        busy_n   = 1'b0;
                        locked_n = 1'b1;
                        mode_n   = track_en;
                        state_n  = track_en ? TRACK : LOCKED;
                    end else begin
                        bit_idx_n          = bit_idx - 1'b1;
                        gamma_n[bit_idx_n] = 1'b1;
                        state_n            = SETTLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcc_sar_ctrl.sv
// Bench for dcc_sar_ctrl: behavioural detector (pd_in = gamma > target) and an
// arithmetic model of the SAR result, latency and saturating track steps.
module tb_dcc_sar_ctrl;
    import dcc_pkg::*;

    localparam int DB    = 5;
    localparam int ST    = 4;
    localparam int NS    = 3;
    localparam int ROUND = ST + NS + 1;
    localparam int LAT   = 1 + DB * ROUND - 1;
    localparam int GMAX  = (1 << DB) - 1;

    logic          clk_in = 1'b0;
    logic          rst, start, track_en, pd_in;
    logic [DB-1:0] gamma;
    logic          busy, locked;

    int target = 0;
    bit noise  = 1'b0;
    int n_cmp  = 0;
    int n_fail = 0;
    int g;

    dcc_sar_ctrl #(.delay_bits(DB), .SETTLE_CYCLES(ST), .SAMPLES(NS)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .track_en (track_en),
        .pd_in    (pd_in),
        .gamma    (gamma),
        .busy     (busy),
        .locked   (locked)
    );

    always #5 clk_in = ~clk_in;

    always_comb pd_in = ((int'(gamma) > target) ? 1'b1 : 1'b0) ^ noise;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Binary search result for a threshold detector, one entry per trial code.
    task automatic sar_run(input int tgt, input bit extra_starts, input bit noisy, output int final_g);
        int trial[DB+1];
        int m, off;
        m = 1 << (DB - 1);
        trial[0] = m;
        for (int b = DB - 1; b >= 0; b--) begin
            if (m > tgt) m &= ~(1 << b);
            if (b > 0) m |= 1 << (b - 1);
            trial[DB - b] = m;
        end
        final_g = trial[DB];
        off = 3;
        target = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_trial", 32'(gamma), 32'(trial[0]));
        check("busy_at_start", 32'(busy), 32'd1);
        check("locked_low_at_start", 32'(locked), 32'd0);
        for (int c = 1; c <= LAT; c++) begin
            if (c % ROUND == 1) off = $urandom_range(3, 5);
            start = extra_starts && (c == 5 || c == 12);
            noise = noisy && (c % ROUND == off);
            tick();
            start = 1'b0;
            noise = 1'b0;
            if (c % ROUND == 0 && c < LAT) begin
                check("sar_trial", 32'(gamma), 32'(trial[c / ROUND]));
                check("busy_mid_search", 32'(busy), 32'd1);
            end
            if (c == LAT - 1) begin
                check("locked_not_early", 32'(locked), 32'd0);
                check("busy_before_lock", 32'(busy), 32'd1);
            end
        end
        check("locked_latency", 32'(locked), 32'd1);
        check("busy_cleared_at_lock", 32'(busy), 32'd0);
        check("final_gamma", 32'(gamma), 32'(final_g));
    endtask

    task automatic track_run(input int g0, input int tgt, input int rounds, output int g_out);
        int m;
        m = g0;
        target = tgt;
        for (int r = 0; r < rounds; r++) begin
            for (int c = 1; c <= ROUND; c++) begin
                tick();
                if (c == ROUND - 1) check("track_hold", 32'(gamma), 32'(m));
            end
            if (m > tgt) m = (m > 0) ? m - 1 : 0;
            else         m = (m < GMAX) ? m + 1 : GMAX;
            check("track_step", 32'(gamma), 32'(m));
            check("track_locked", 32'(locked), 32'd1);
            check("track_busy", 32'(busy), 32'd0);
        end
        g_out = m;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        track_en = 1'b0;
        repeat (3) tick();
        check("rst_gamma", 32'(gamma), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick();

        sar_run(19, 1'b0, 1'b0, g);
        check("target19_value", 32'(g), 32'd19);
        sar_run(0, 1'b0, 1'b0, g);
        sar_run(31, 1'b0, 1'b0, g);
        sar_run(19, 1'b1, 1'b0, g);

        // Reset in the middle of a search.
        target = 19;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (18) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_gamma", 32'(gamma), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        tick();
        sar_run(19, 1'b0, 1'b0, g);

        sar_run(19, 1'b0, 1'b1, g);
        for (int i = 0; i < 4; i++)
            sar_run(int'($urandom_range(0, GMAX)), 1'b0, 1'($urandom_range(0, 1)), g);

        // Tracking a step from 19 to 21, then leaving track mode.
        track_en = 1'b1;
        sar_run(19, 1'b0, 1'b0, g);
        track_run(g, 21, 5, g);
        check("dither_value", 32'(g), 32'd22);
        track_en = 1'b0;
        track_run(g, 21, 1, g);
        check("track_exit_state", 32'(dut.state), 32'(LOCKED));

        // Upper and lower saturation while tracking.
        track_en = 1'b1;
        sar_run(31, 1'b0, 1'b0, g);
        track_run(g, 40, 3, g);
        track_en = 1'b0;
        track_run(g, 40, 1, g);
        track_en = 1'b1;
        sar_run(0, 1'b0, 1'b0, g);
        track_run(g, -1, 3, g);
        track_en = 1'b0;
        track_run(g, -1, 1, g);

        // Random drift while tracking.
        track_en = 1'b1;
        sar_run(int'($urandom_range(0, GMAX)), 1'b0, 1'b0, g);
        track_run(g, int'($urandom_range(0, GMAX)), 6, g);
        track_en = 1'b0;
        track_run(g, target, 1, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcc_sar_ctrl.md
Name: dcc_sar_ctrl

Overview:
- Duty-cycle-correction loop controller that sits directly upstream of the tapped delay line and drives its tap-select code `gamma`.
- Consumes the phase/duty detector decision and runs a binary (SAR) search for the tap code. It can then optionally track drift one LSB at a time.
- Each trial code is held for a settle window, then the detector output is majority-voted over several samples before any decision.

Parameters:
- delay_bits, 5, width of gamma; must match the delay line's delay_bits.
- SETTLE_CYCLES, 4, cycles gamma is held before sampling; legal range is 3 or more, which covers the 2-flop detector synchronizer.
- SAMPLES, 3, detector samples per decision; legal range is 1..15.

Ports:
- clk_in  input  1  single system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle pulse; launches a search. Honoured only in IDLE or LOCKED.
- track_en  input  1  level; when high, the block enters TRACK after the search completes.
- pd_in  input  1  detector decision, asynchronous; 1 means the current gamma is too large.
- gamma  output  delay_bits  tap code to the delay line (registered).
- busy  output  1  high while in SETTLE, SAMPLE or DECIDE of a SAR search.
- locked  output  1  high once the SAR search completes; stays high through TRACK.

Behaviour:
- Reset (rst=1 at a clock edge) gives: gamma=0, busy=0, locked=0, state=IDLE, counters=0, synchronizer flops=0. The same applies to reset mid-operation; any search in progress is abandoned.
- pd_in passes through a 2-flop synchronizer; only pd_s, the synchronized value, is used.
- States and transitions:
  - IDLE, on start: bit_idx=delay_bits-1; gamma=1<<(delay_bits-1); busy=1; locked=0; go to SETTLE with cnt=SETTLE_CYCLES-1.
  - SETTLE: decrement cnt each cycle; at cnt==0 go to SAMPLE, clear ones, and set scnt=SAMPLES-1.
  - SAMPLE: ones += pd_s each cycle; at scnt==0 go to DECIDE. The last sample taken is included in ones.
  - DECIDE, SAR step: if 2*ones > SAMPLES, clear gamma[bit_idx]; otherwise keep it (a tie keeps the bit).
    - If bit_idx==0: busy=0, locked=1; go to TRACK if track_en, else LOCKED.
    - Otherwise: bit_idx--, set gamma[bit_idx], go to SETTLE.
  - LOCKED: gamma is held. start restarts the search (behaves as from IDLE, locked drops to 0). track_en=1 goes to SETTLE in track mode.
  - TRACK: runs a SETTLE to SAMPLE to DECIDE round with busy=0. The decide step is:
    - 2*ones > SAMPLES gives gamma-1, saturating at 0.
    - 2*ones < SAMPLES gives gamma+1, saturating at 2^delay_bits-1.
    - A tie holds gamma.
    - After the decide, start another round while track_en=1; otherwise go to LOCKED.
- A mode flag distinguishes SAR rounds from track rounds.
- Timing and handshake:
  - start is ignored while busy=1, and also during track rounds.
  - If start and rst occur in the same cycle, reset wins.
  - gamma changes only on the cycle a state is entered from IDLE/LOCKED, or in DECIDE.
  - SAR latency: locked rises exactly 1 + delay_bits*(SETTLE_CYCLES+SAMPLES+1) - 1 cycles after the start cycle. This is 40 cycles for the defaults.
  - Track step period: SETTLE_CYCLES+SAMPLES+1 cycles.
- Width rule: the ones counter is 4 bits; the compare 2*ones is computed on 5 bits.

Decomposition:
- Shared package dcc_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DECIDE, LOCKED, TRACK);
  - the default constants DCC_DELAY_BITS=5, DCC_SETTLE=4, DCC_SAMPLES=3, shared with the delay-line wrapper.
- One sub-module: sync2, a 2-flop bit synchronizer with synchronous reset, used for pd_in. The rest of the logic is a single FSM in dcc_sar_ctrl.

Test Plan:
- All scenarios use the defaults. The behavioural detector model drives pd_in=(gamma>target), updated immediately.
- target=19, start pulse -> gamma sequence 16,24,20,18,19; final gamma=19; locked=1 exactly 40 cycles after start; busy=0 on the same cycle.
- target=0 -> final gamma=0. target=31 -> final gamma=31. Both lock in 40 cycles.
- Lock at target=19 with track_en=1, then step target to 21 -> gamma goes 20, 21, 22, one step per 8-cycle round. After that gamma dithers between 21 and 22. locked stays 1 and busy stays 0 throughout.
- Tracking with target=40 (above range) from gamma=31 -> gamma saturates and holds at 31, with no wrap to 0.
- start pulses at cycles 5 and 12 after the first start -> both are ignored; the result and latency are identical to the 19-target case.
- rst asserted at cycle 20 of a search -> the next cycle shows gamma=0, busy=0, locked=0 and state IDLE. A new start then completes normally.
- Noise check: with target=19, force pd_in wrong on 1 of 3 samples in each round -> the majority vote still yields gamma=19.
